uart_rx16: RTL
==============

UART_RX16 -- requirements
Module: uart_rx16

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx_serial_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 The block SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data this cycle.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.
REQ-011 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch.

Function
REQ-012 rx_serial_in SHALL pass through a 2-flop synchronizer before use; this adds 2 cycles of input latency.
REQ-013 The block SHALL generate an oversample tick at 16x BAUD, with divisor CLK_FREQ/(BAUD*16) using integer truncation (minimum 1).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE SHALL go to START on a synchronized high-to-low transition, and SHALL restart the sample counter at 0.
REQ-016 Each bit SHALL be decided by a 2-of-3 majority of oversamples 7, 8 and 9.
REQ-017 In START, a majority-high result SHALL be treated as a glitch: return to IDLE, no outputs change.
REQ-018 DATA SHALL capture 8 bits LSB-first, then go to PARITY if compiled in, else to STOP.
REQ-019 In STOP, a majority-high result SHALL transfer the shift register to rx_data and assert rx_valid exactly 1 cycle after the stop-bit decision, then go to IDLE.
REQ-020 In STOP, a majority-low result SHALL pulse frame_err, discard the byte, leave rx_data/rx_valid unchanged, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until the synchronized line is high for one full bit time (16 ticks), then go to IDLE.
REQ-022 rx_valid SHALL stay high until a cycle with rx_valid and rx_ready both high; it SHALL clear on the following edge.
REQ-023 If a new byte completes while rx_valid is high and rx_ready is low, the new byte SHALL be dropped, the held byte kept, and overrun pulsed.
REQ-024 If a new byte completes in the same cycle that rx_ready consumes the held byte, the new byte SHALL load, rx_valid SHALL stay high, and overrun SHALL stay low.

Reset
REQ-025 While rst is high at a clock edge, the FSM SHALL go to IDLE and the tick/sample/bit counters SHALL clear.
REQ-026 Reset SHALL set rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, parity_err=0, and the synchronizer flops to 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, reception resumes only on the next falling edge.

Configuration
REQ-028 Macro UART_RX16_PARITY_EN defined: the block SHALL expect one even-parity bit after bit 7; on mismatch it SHALL pulse parity_err and still deliver the byte if the stop bit is good.
REQ-029 Macro UART_RX16_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE=16 constant, and a divisor-calculation function shared with the transmitter.
REQ-031 Sub-module uart_baud_tick SHALL implement the 16x tick generator; the FSM, majority vote and output register SHALL be in uart_rx16.

Verification (CLK_FREQ=16000000, BAUD=1000000: 1 tick/cycle, 16 cycles/bit)
REQ-032 Send 8'hA5 with a good stop bit and rx_ready held high -> rx_data=8'hA5, rx_valid high for exactly 1 cycle, no error pulses.
REQ-033 Send 8'h3C then 8'hC3 with rx_ready=0 -> rx_data stays 8'h3C, overrun pulses once; then pulse rx_ready -> rx_valid clears.
REQ-034 Send 8'h55 with the stop bit forced low -> frame_err pulses once, rx_valid stays 0; hold the line low for 40 cycles, then high for 16 cycles, then send 8'h0F -> 8'h0F is received.
REQ-035 Apply a 4-cycle low glitch on an idle line -> no rx_valid and no errors; the next 8'h81 is received correctly.
REQ-036 Assert rst for 1 cycle during bit 4 of 8'hFF -> all outputs go to reset values and no byte is delivered; the next 8'h12 is received.
REQ-037 With UART_RX16_PARITY_EN defined, send 8'h07 with the parity bit set to 0 -> parity_err pulses and rx_data=8'h07 is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample ratio and helpers.
// The PARITY state exists only when UART_RX16_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX16_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_t;

   // Clocks per oversample tick, truncated, never below one.
   function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                input int unsigned baud);
      int unsigned div;
      div = clk_freq / (baud * OVERSAMPLE);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks (16x baud).
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Next-count and tick decode.
   always_comb begin
      if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + CW'(1);
         tick_d = 1'b0;
      end
   end

   // Divider state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx16.sv
// 16x-oversampled UART receiver with 2-of-3 bit voting and a one-deep output slot.
// Optional even parity bit enabled by defining UART_RX16_PARITY_EN.
module uart_rx16
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned DIV = calc_divisor(CLK_FREQ, BAUD);

   logic       tick_s;
   logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   rx_state_t  state_q, state_d;
   logic [3:0] sample_cnt_q, sample_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       v7_q, v7_d, v8_q, v8_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;
   logic       load_s, vote_s, decide_s;
`ifdef UART_RX16_PARITY_EN
   logic       parity_err_q, parity_err_d;
`endif

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_i  (clk),
      .rst_i  (rst),
      .tick_o (tick_s)
   );

   // Frame FSM, sample bookkeeping and output slot next-state.
   always_comb begin
      sync1_d      = rx_serial_in;
      sync2_d      = sync1_q;
      prev_d       = sync2_q;
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      v7_d         = v7_q;
      v8_d         = v8_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q & ~rx_ready;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      load_s       = 1'b0;
      vote_s       = maj3(v7_q, v8_q, sync2_q);
      decide_s     = tick_s && (sample_cnt_q == 4'd9);
`ifdef UART_RX16_PARITY_EN
      parity_err_d = 1'b0;
`endif

      if (tick_s && (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE)) begin
         sample_cnt_d = sample_cnt_q + 4'd1;
         if (sample_cnt_q == 4'd7) v7_d = sync2_q; else v7_d = v7_q;
         if (sample_cnt_q == 4'd8) v8_d = sync2_q; else v8_d = v8_q;
      end else begin
         sample_cnt_d = sample_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d      = ST_START;
               sample_cnt_d = 4'd0;
               bit_cnt_d    = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (decide_s) state_d = vote_s ? ST_IDLE : ST_DATA;
            else          state_d = ST_START;
         end
         ST_DATA: begin
            if (decide_s) begin
               shift_d   = {vote_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX16_PARITY_EN
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
`else
               if (bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
               else                   state_d = ST_DATA;
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef UART_RX16_PARITY_EN
         ST_PARITY: begin
            if (decide_s) begin
               parity_err_d = (vote_s != even_parity(shift_q));
               state_d      = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (decide_s) begin
               if (vote_s) begin
                  load_s  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d  = 1'b1;
                  state_d      = ST_WAIT_IDLE;
                  sample_cnt_d = 4'd0;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            // Counts consecutive high ticks; any low sample restarts the bit time.
            if (tick_s) begin
               if (!sync2_q) begin
                  sample_cnt_d = 4'd0;
               end else if (sample_cnt_q == 4'd15) begin
                  sample_cnt_d = 4'd0;
                  state_d      = ST_IDLE;
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            sample_cnt_d = 4'd0;
            bit_cnt_d    = 3'd0;
         end
      endcase

      // A consume in the same cycle frees the slot for the new byte.
      if (load_s) begin
         if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
         end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end
      end else begin
         rx_data_d = rx_data_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         state_q      <= ST_IDLE;
         sample_cnt_q <= 4'd0;
         bit_cnt_q    <= 3'd0;
         v7_q         <= 1'b1;
         v8_q         <= 1'b1;
         shift_q      <= 8'h00;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX16_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         v7_q         <= v7_d;
         v8_q         <= v8_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX16_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX16_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
